// File: rtl/core_wb_arbiter_pkg.sv
// Shared types and defaults for the writeback arbiter: the writeback line
// carried from an execution unit to a register-file write port.
package core_wb_arbiter_pkg;

  localparam int REG_W  = 5;
  localparam int WORD_W = 32;

  typedef logic [REG_W-1:0]  reg_num;
  typedef logic [WORD_W-1:0] word;

  typedef struct packed {
    logic   valid;
    reg_num rd;
    word    value;
  } wb_line;

  // Default configuration: two ALUs, three shared units, two write ports.
  localparam int WB_N_SRC   = 5;
  localparam int WB_N_FIXED = 2;
  localparam int WB_N_PORTS = 2;

  // Width of an index into n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/core_wb_arbiter_if.sv
// Writeback bundle between the EX units (master) and the arbiter (slave).
interface core_wb_arbiter_if
  import core_wb_arbiter_pkg::*;
#(
  parameter int N_SRC   = WB_N_SRC,
  parameter int N_PORTS = WB_N_PORTS
);

  wb_line [N_SRC-1:0]   wb_in;
  logic   [N_SRC-1:0]   wb_stall;
  wb_line [N_PORTS-1:0] wr;
  logic   [31:0]        stall_cnt;

  modport master (
    output wb_in,
    input  wb_stall,
    input  wr,
    input  stall_cnt
  );

  modport slave (
    input  wb_in,
    output wb_stall,
    output wr,
    output stall_cnt
  );

endinterface

// File: rtl/core_wb_rr_pick.sv
// Circular priority picker: scans requests starting at start_i and grants up
// to limit_i of them in scan order, skipping any request that conflicts with
// one already granted in the same scan. slot_o[s] is the one-hot grant that
// occupies the s-th free port.
module core_wb_rr_pick
  import core_wb_arbiter_pkg::*;
#(
  parameter int N  = 3,
  parameter int K  = 2,
  parameter int PW = idx_w(N),
  parameter int CW = $clog2(K + 1)
) (
  input  logic [N-1:0]        req_i,
  input  logic [N-1:0][N-1:0] conf_i,
  input  logic [PW-1:0]       start_i,
  input  logic [CW-1:0]       limit_i,
  output logic [N-1:0]        grant_o,
  output logic [K-1:0][N-1:0] slot_o,
  output logic [CW-1:0]       count_o,
  output logic [PW-1:0]       last_o
);

  logic [N-1:0][PW-1:0] scan_idx;

  // Request index visited at scan position gi, wrapping modulo N.
  for (genvar gi = 0; gi < N; gi++) begin : g_scan
    logic [PW:0] sum;
    assign sum = {1'b0, start_i} + (PW+1)'(gi);
    assign scan_idx[gi] = (sum >= (PW+1)'(N)) ? PW'(sum - (PW+1)'(N)) : PW'(sum);
  end

  // Walk the scan order once, granting eligible requests until the limit is hit.
  always_comb begin
    grant_o = '0;
    slot_o  = '0;
    count_o = '0;
    last_o  = '0;
    for (int s = 0; s < N; s++) begin
      if (req_i[scan_idx[s]] && (count_o < limit_i) &&
          ((conf_i[scan_idx[s]] & grant_o) == '0)) begin
        grant_o[scan_idx[s]]          = 1'b1;
        slot_o[count_o][scan_idx[s]]  = 1'b1;
        count_o                       = count_o + CW'(1);
        last_o                        = scan_idx[s];
      end
    end
  end

endmodule

// File: rtl/core_wb_arbiter.sv
// Writeback arbiter: fixed-latency sources always take the lowest write ports;
// the remaining sources share whatever ports are left round-robin and are
// stalled when they lose or when their rd collides with an earlier winner.
// Write ports are registered, so a grant in cycle t is visible in t+1.
module core_wb_arbiter
  import core_wb_arbiter_pkg::*;
#(
  parameter int N_SRC   = WB_N_SRC,
  parameter int N_FIXED = WB_N_FIXED,
  parameter int N_PORTS = WB_N_PORTS
) (
  input logic              clk,
  input logic              rst_n,
  core_wb_arbiter_if.slave wb
);

  localparam int N_VAR = N_SRC - N_FIXED;
  localparam int VW    = idx_w(N_VAR);
  localparam int CW    = $clog2(N_PORTS + 1);

  if (N_FIXED > N_PORTS) begin : g_cfg_fixed
    $error("core_wb_arbiter: N_FIXED (%0d) exceeds N_PORTS (%0d)", N_FIXED, N_PORTS);
  end
  if (N_FIXED >= N_SRC) begin : g_cfg_var
    $error("core_wb_arbiter: need at least one variable source (N_SRC=%0d N_FIXED=%0d)",
           N_SRC, N_FIXED);
  end

  // rr_q holds the round-robin pointer relative to N_FIXED (0 == source N_FIXED).
  logic [VW-1:0]               rr_q, rr_d;
  wb_line [N_PORTS-1:0]        wr_q, wr_d;
  logic [31:0]                 stall_cnt_q;

  logic [CW-1:0]               n_fixed_valid;
  logic [CW-1:0]               free_ports;
  logic [N_VAR-1:0]            var_req;
  logic [N_VAR-1:0][N_VAR-1:0] var_conf;
  logic [N_VAR-1:0]            var_grant;
  logic [N_PORTS-1:0][N_VAR-1:0] var_slot;
  logic [CW-1:0]               pick_cnt;
  logic [VW-1:0]               pick_last;
  logic [N_SRC-1:0]            stall_vec;
  int                          fill_idx;

  // Count the fixed sources that claim a port this cycle.
  always_comb begin
    n_fixed_valid = '0;
    for (int f = 0; f < N_FIXED; f++) begin
      if (wb.wb_in[f].valid) n_fixed_valid = n_fixed_valid + CW'(1);
    end
  end

  assign free_ports = CW'(N_PORTS) - n_fixed_valid;

  // A variable source may compete only if its rd misses every valid fixed rd;
  // pairwise rd equality among variables lets the picker drop later duplicates.
  always_comb begin
    var_req  = '0;
    var_conf = '0;
    for (int v = 0; v < N_VAR; v++) begin
      var_req[v] = wb.wb_in[N_FIXED+v].valid;
      for (int f = 0; f < N_FIXED; f++) begin
        if (wb.wb_in[f].valid && (wb.wb_in[f].rd == wb.wb_in[N_FIXED+v].rd))
          var_req[v] = 1'b0;
      end
      for (int w = 0; w < N_VAR; w++) begin
        if ((w != v) && (wb.wb_in[N_FIXED+w].rd == wb.wb_in[N_FIXED+v].rd))
          var_conf[v][w] = 1'b1;
      end
    end
  end

  core_wb_rr_pick #(
    .N  (N_VAR),
    .K  (N_PORTS),
    .PW (VW),
    .CW (CW)
  ) u_pick (
    .req_i   (var_req),
    .conf_i  (var_conf),
    .start_i (rr_q),
    .limit_i (free_ports),
    .grant_o (var_grant),
    .slot_o  (var_slot),
    .count_o (pick_cnt),
    .last_o  (pick_last)
  );

  // Fixed sources never stall; a variable source stalls when valid but not granted.
  always_comb begin
    stall_vec = '0;
    for (int v = 0; v < N_VAR; v++) begin
      stall_vec[N_FIXED+v] = wb.wb_in[N_FIXED+v].valid & ~var_grant[v];
    end
  end

  // Pack ports: fixed grants in index order, then variable grants in scan order.
  always_comb begin
    wr_d     = '0;
    fill_idx = 0;
    for (int f = 0; f < N_FIXED; f++) begin
      if (wb.wb_in[f].valid && (fill_idx < N_PORTS)) begin
        wr_d[fill_idx] = wb.wb_in[f];
        fill_idx       = fill_idx + 1;
      end
    end
    for (int s = 0; s < N_PORTS; s++) begin
      if ((var_slot[s] != '0) && (fill_idx < N_PORTS)) begin
        for (int v = 0; v < N_VAR; v++) begin
          if (var_slot[s][v]) wr_d[fill_idx] = wb.wb_in[N_FIXED+v];
        end
        fill_idx = fill_idx + 1;
      end
    end
  end

  // Advance the pointer past the last variable winner; hold it when none won.
  always_comb begin
    rr_d = rr_q;
    if (pick_cnt != '0) begin
      rr_d = (pick_last == VW'(N_VAR - 1)) ? '0 : pick_last + VW'(1);
    end
  end

  // Register the write ports, round-robin pointer and saturating stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q        <= '0;
      rr_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rr_q <= rr_d;
      if ((|stall_vec) && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign wb.wb_stall  = stall_vec;
  assign wb.wr        = wr_q;
  assign wb.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_core_wb_arbiter.sv
// Self-checking bench for core_wb_arbiter: default 5/2/2 configuration plus a
// 4-source, 1-fixed, 3-port instance. Expected write-port contents are queued
// when a cycle's inputs are driven and popped one cycle later.
module tb_core_wb_arbiter;
  import core_wb_arbiter_pkg::*;

  typedef wb_line [1:0] wr2_t;
  typedef wb_line [2:0] wr3_t;
  typedef wb_line [4:0] in5_t;
  typedef wb_line [3:0] in4_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fails  = 0;
  int   cyc      = 0;

  wr2_t exp_q[$];
  wr3_t exp3_q[$];

  // Per-test stimulus tables (up to 4 cycles).
  in5_t       in_t[4];
  logic [4:0] st_t[4];
  wr2_t       ex_t[4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  core_wb_arbiter_if #(.N_SRC(5), .N_PORTS(2)) bus ();
  core_wb_arbiter_if #(.N_SRC(4), .N_PORTS(3)) bus3 ();

  core_wb_arbiter #(.N_SRC(5), .N_FIXED(2), .N_PORTS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (bus)
  );

  core_wb_arbiter #(.N_SRC(4), .N_FIXED(1), .N_PORTS(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (bus3)
  );

  function automatic wb_line mk(input int rd, input int unsigned val);
    wb_line l;
    l.valid = 1'b1;
    l.rd    = reg_num'(rd);
    l.value = word'(val);
    return l;
  endfunction

  task automatic apply_reset();
    rst_n       = 1'b0;
    bus.wb_in   = '0;
    bus3.wb_in  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    exp3_q.delete();
  endtask

  // Drive one cycle of inputs and queue the write ports expected next cycle.
  task automatic drive(input in5_t lines, input wr2_t exp);
    @(negedge clk);
    bus.wb_in = lines;
    exp_q.push_back(exp);
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    $display("[reset] cyc %0d wr=%h stall=%b cnt=%0d", cyc, bus.wr, bus.wb_stall, bus.stall_cnt);
    n_checks++;
    if (bus.wr !== '0) begin
      n_fails++; $display("FAIL reset_wr: got %h expected 0", bus.wr);
    end
    n_checks++;
    if (bus.wb_stall !== 5'b0) begin
      n_fails++; $display("FAIL reset_stall: got %b expected 00000", bus.wb_stall);
    end
    n_checks++;
    if (bus.stall_cnt !== 32'd0) begin
      n_fails++; $display("FAIL reset_cnt: got %0d expected 0", bus.stall_cnt);
    end
    n_checks++;
    if (bus3.wr !== '0) begin
      n_fails++; $display("FAIL reset_wr3: got %h expected 0", bus3.wr);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.wr !== '0) begin
      n_fails++; $display("FAIL idle_wr: got %h expected 0", bus.wr);
    end
  endtask

  task automatic test_single_var();
    wr2_t got;
    apply_reset();
    in_t[0] = '0; in_t[0][3] = mk(5, 32'h1234);
    st_t[0] = 5'b00000;
    ex_t[0] = '0; ex_t[0][0] = mk(5, 32'h1234);
    in_t[1] = '0; st_t[1] = 5'b00000; ex_t[1] = '0;
    for (int i = 0; i < 2; i++) begin
      drive(in_t[i], ex_t[i]);
      #1;
      n_checks++;
      if (bus.wb_stall !== st_t[i]) begin
        n_fails++; $display("FAIL single_stall[%0d]: got %b expected %b", i, bus.wb_stall, st_t[i]);
      end
      @(posedge clk); #1;
      got = exp_q.pop_front();
      $display("[single] cyc %0d wr0=%h wr1=%h", cyc, bus.wr[0], bus.wr[1]);
      n_checks++;
      if (bus.wr !== got) begin
        n_fails++; $display("FAIL single_wr[%0d]: got %h expected %h", i, bus.wr, got);
      end
    end
  endtask

  task automatic test_fixed_priority();
    wr2_t got;
    int   cnt_t[3];
    apply_reset();
    in_t[0] = '0;
    in_t[0][0] = mk(1, 32'hA0); in_t[0][1] = mk(2, 32'hA1); in_t[0][2] = mk(3, 32'hB2);
    st_t[0] = 5'b00100;
    ex_t[0] = '0; ex_t[0][0] = mk(1, 32'hA0); ex_t[0][1] = mk(2, 32'hA1);
    cnt_t[0] = 1;
    in_t[1] = in_t[0]; st_t[1] = st_t[0]; ex_t[1] = ex_t[0]; cnt_t[1] = 2;
    in_t[2] = '0; in_t[2][2] = mk(3, 32'hB2);
    st_t[2] = 5'b00000;
    ex_t[2] = '0; ex_t[2][0] = mk(3, 32'hB2);
    cnt_t[2] = 2;
    for (int i = 0; i < 3; i++) begin
      drive(in_t[i], ex_t[i]);
      #1;
      n_checks++;
      if (bus.wb_stall !== st_t[i]) begin
        n_fails++; $display("FAIL fixed_stall[%0d]: got %b expected %b", i, bus.wb_stall, st_t[i]);
      end
      @(posedge clk); #1;
      got = exp_q.pop_front();
      $display("[fixed] cyc %0d wr0=%h wr1=%h cnt=%0d", cyc, bus.wr[0], bus.wr[1], bus.stall_cnt);
      n_checks++;
      if (bus.wr !== got) begin
        n_fails++; $display("FAIL fixed_wr[%0d]: got %h expected %h", i, bus.wr, got);
      end
      n_checks++;
      if (bus.stall_cnt !== 32'(cnt_t[i])) begin
        n_fails++; $display("FAIL fixed_cnt[%0d]: got %0d expected %0d", i, bus.stall_cnt, cnt_t[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    wr2_t   got;
    wb_line l2, l3, l4;
    apply_reset();
    l2 = mk(10, 32'h200); l3 = mk(11, 32'h300); l4 = mk(12, 32'h400);
    for (int i = 0; i < 4; i++) begin
      in_t[i] = '0; in_t[i][2] = l2; in_t[i][3] = l3; in_t[i][4] = l4;
    end
    ex_t[0][0] = l2; ex_t[0][1] = l3; st_t[0] = 5'b10000;
    ex_t[1][0] = l4; ex_t[1][1] = l2; st_t[1] = 5'b01000;
    ex_t[2][0] = l3; ex_t[2][1] = l4; st_t[2] = 5'b00100;
    ex_t[3][0] = l2; ex_t[3][1] = l3; st_t[3] = 5'b10000;
    for (int i = 0; i < 4; i++) begin
      drive(in_t[i], ex_t[i]);
      #1;
      n_checks++;
      if (bus.wb_stall !== st_t[i]) begin
        n_fails++; $display("FAIL rr_stall[%0d]: got %b expected %b", i, bus.wb_stall, st_t[i]);
      end
      @(posedge clk); #1;
      got = exp_q.pop_front();
      $display("[rr] cyc %0d wr0=r%0d wr1=r%0d", cyc, bus.wr[0].rd, bus.wr[1].rd);
      n_checks++;
      if (bus.wr !== got) begin
        n_fails++; $display("FAIL rr_wr[%0d]: got %h expected %h", i, bus.wr, got);
      end
    end
  endtask

  task automatic test_rd_conflict();
    wr2_t got;
    apply_reset();
    in_t[0] = '0; in_t[0][0] = mk(7, 32'h70); in_t[0][2] = mk(7, 32'h72);
    st_t[0] = 5'b00100;
    ex_t[0] = '0; ex_t[0][0] = mk(7, 32'h70);
    in_t[1] = '0; in_t[1][2] = mk(8, 32'h82); in_t[1][3] = mk(8, 32'h83);
    st_t[1] = 5'b01000;
    ex_t[1] = '0; ex_t[1][0] = mk(8, 32'h82);
    for (int i = 0; i < 2; i++) begin
      drive(in_t[i], ex_t[i]);
      #1;
      n_checks++;
      if (bus.wb_stall !== st_t[i]) begin
        n_fails++; $display("FAIL conflict_stall[%0d]: got %b expected %b", i, bus.wb_stall, st_t[i]);
      end
      @(posedge clk); #1;
      got = exp_q.pop_front();
      $display("[conflict] cyc %0d wr0=%h wr1=%h", cyc, bus.wr[0], bus.wr[1]);
      n_checks++;
      if (bus.wr !== got) begin
        n_fails++; $display("FAIL conflict_wr[%0d]: got %h expected %h", i, bus.wr, got);
      end
    end
  endtask

  task automatic test_async_reset();
    wr2_t got;
    apply_reset();
    in_t[0] = '0; in_t[0][0] = mk(4, 32'h44); in_t[0][3] = mk(9, 32'h93);
    ex_t[0] = '0; ex_t[0][0] = mk(4, 32'h44); ex_t[0][1] = mk(9, 32'h93);
    drive(in_t[0], ex_t[0]);
    @(posedge clk); #1;
    got = exp_q.pop_front();
    $display("[areset] cyc %0d wr0=%h wr1=%h", cyc, bus.wr[0], bus.wr[1]);
    n_checks++;
    if (bus.wr !== got) begin
      n_fails++; $display("FAIL areset_pre_wr: got %h expected %h", bus.wr, got);
    end
    // Drop reset between clock edges: the ports must clear without a clock.
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.wr[0].valid !== 1'b0 || bus.wr !== '0) begin
      n_fails++; $display("FAIL areset_async: got %h expected 0", bus.wr);
    end
    bus.wb_in = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // Pointer must be back at source 2: grants (2,3), not (4,2).
    in_t[1] = '0;
    in_t[1][2] = mk(10, 32'h200); in_t[1][3] = mk(11, 32'h300); in_t[1][4] = mk(12, 32'h400);
    ex_t[1][0] = mk(10, 32'h200); ex_t[1][1] = mk(11, 32'h300);
    drive(in_t[1], ex_t[1]);
    #1;
    n_checks++;
    if (bus.wb_stall !== 5'b10000) begin
      n_fails++; $display("FAIL areset_stall: got %b expected 10000", bus.wb_stall);
    end
    @(posedge clk); #1;
    got = exp_q.pop_front();
    $display("[areset] cyc %0d wr0=r%0d wr1=r%0d", cyc, bus.wr[0].rd, bus.wr[1].rd);
    n_checks++;
    if (bus.wr !== got) begin
      n_fails++; $display("FAIL areset_rr: got %h expected %h", bus.wr, got);
    end
  endtask

  task automatic test_three_port();
    in4_t       in3;
    wr3_t       e3, got3;
    logic [3:0] st3[2];
    wr3_t       ex3[2];
    apply_reset();
    in3 = '0;
    in3[0] = mk(1, 32'h10); in3[1] = mk(2, 32'h11);
    in3[2] = mk(3, 32'h12); in3[3] = mk(4, 32'h13);
    st3[0] = 4'b1000; ex3[0][0] = in3[0]; ex3[0][1] = in3[1]; ex3[0][2] = in3[2];
    st3[1] = 4'b0100; ex3[1][0] = in3[0]; ex3[1][1] = in3[3]; ex3[1][2] = in3[1];
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus3.wb_in = in3;
      e3 = ex3[i];
      exp3_q.push_back(e3);
      #1;
      n_checks++;
      if (bus3.wb_stall !== st3[i]) begin
        n_fails++; $display("FAIL port3_stall[%0d]: got %b expected %b", i, bus3.wb_stall, st3[i]);
      end
      @(posedge clk); #1;
      got3 = exp3_q.pop_front();
      $display("[port3] cyc %0d wr0=r%0d wr1=r%0d wr2=r%0d", cyc,
               bus3.wr[0].rd, bus3.wr[1].rd, bus3.wr[2].rd);
      n_checks++;
      if (bus3.wr !== got3) begin
        n_fails++; $display("FAIL port3_wr[%0d]: got %h expected %h", i, bus3.wr, got3);
      end
    end
    bus3.wb_in = '0;
  endtask

  initial begin
    bus.wb_in  = '0;
    bus3.wb_in = '0;
    test_reset();
    test_single_var();
    test_fixed_priority();
    test_round_robin();
    test_rd_conflict();
    test_async_reset();
    test_three_port();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
